// File: rtl/pipe_pkg.sv
// Shared definitions for the generic pipeline stage register: stage state
// encoding, MEM/WB field widths and statistics counter width.
package pipe_pkg;

  localparam int WB_DATA_W = 69;
  localparam int WB_CTRL_W = 2;
  localparam int STAT_W    = 32;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } stageState_e;

  // A stage can take a new entry whenever the skid slot is still free.
  function automatic logic canAccept(input stageState_e st);
    return (st != ST_FULL);
  endfunction

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter with enable; sticks at all-ones instead of wrapping.
module pipe_sat_cnt
  import pipe_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  output logic [STAT_W-1:0] cnt_o
);

  logic [STAT_W-1:0] cnt_r;
  logic              atMax_s;

  assign atMax_s = (cnt_r == {STAT_W{1'b1}});

  // Count enabled cycles until the counter reaches its ceiling.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r <= {STAT_W{1'b0}};
    end else if (en_i && !atMax_s) begin
      cnt_r <= cnt_r + {{(STAT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt_o = cnt_r;

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic valid/ready pipeline stage register with a 2-entry skid buffer and
// synchronous flush. Define PIPE_STAGE_STATS_EN to add stall/bubble counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int CTRL_W = WB_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [STAT_W-1:0] stall_cnt_o,
  output logic [STAT_W-1:0] bubble_cnt_o
`endif
);

  stageState_e       state_r;
  stageState_e       stateNext_s;
  logic [DATA_W-1:0] mainData_r;
  logic [CTRL_W-1:0] mainCtrl_r;
  logic [DATA_W-1:0] skidData_r;
  logic [CTRL_W-1:0] skidCtrl_r;

  logic loadMainIn_s;
  logic loadMainSkid_s;
  logic loadSkid_s;
  logic clearCtrl_s;

  // Next-state and register-load decode; flush overrides every transfer.
  always_comb begin
    stateNext_s    = state_r;
    loadMainIn_s   = 1'b0;
    loadMainSkid_s = 1'b0;
    loadSkid_s     = 1'b0;
    clearCtrl_s    = 1'b0;
    if (flush_i) begin
      stateNext_s = ST_EMPTY;
      clearCtrl_s = 1'b1;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (valid_i) begin
            loadMainIn_s = 1'b1;
            stateNext_s  = ST_BUSY;
          end else begin
            stateNext_s  = ST_EMPTY;
          end
        end
        ST_BUSY: begin
          if (valid_i && ready_i) begin
            loadMainIn_s = 1'b1;
            stateNext_s  = ST_BUSY;
          end else if (valid_i) begin
            loadSkid_s   = 1'b1;
            stateNext_s  = ST_FULL;
          end else if (ready_i) begin
            stateNext_s  = ST_EMPTY;
          end else begin
            stateNext_s  = ST_BUSY;
          end
        end
        ST_FULL: begin
          if (ready_i) begin
            loadMainSkid_s = 1'b1;
            stateNext_s    = ST_BUSY;
          end else begin
            stateNext_s    = ST_FULL;
          end
        end
        default: begin
          stateNext_s = ST_EMPTY;
        end
      endcase
    end
  end

  // Stage occupancy state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Head register: payload survives a flush so data_o holds its last value.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mainData_r <= {DATA_W{1'b0}};
      mainCtrl_r <= {CTRL_W{1'b0}};
    end else if (clearCtrl_s) begin
      mainData_r <= mainData_r;
      mainCtrl_r <= {CTRL_W{1'b0}};
    end else if (loadMainIn_s) begin
      mainData_r <= data_i;
      mainCtrl_r <= ctrl_i;
    end else if (loadMainSkid_s) begin
      mainData_r <= skidData_r;
      mainCtrl_r <= skidCtrl_r;
    end else begin
      mainData_r <= mainData_r;
      mainCtrl_r <= mainCtrl_r;
    end
  end

  // Skid register catches the entry accepted while downstream stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skidData_r <= {DATA_W{1'b0}};
      skidCtrl_r <= {CTRL_W{1'b0}};
    end else if (clearCtrl_s) begin
      skidData_r <= skidData_r;
      skidCtrl_r <= {CTRL_W{1'b0}};
    end else if (loadSkid_s) begin
      skidData_r <= data_i;
      skidCtrl_r <= ctrl_i;
    end else begin
      skidData_r <= skidData_r;
      skidCtrl_r <= skidCtrl_r;
    end
  end

  // ready_o decodes state only, so ready_i never reaches it combinationally.
  assign ready_o = canAccept(state_r) & ~rst_i;
  assign valid_o = (state_r != ST_EMPTY);
  assign data_o  = mainData_r;
  assign ctrl_o  = valid_o ? mainCtrl_r : {CTRL_W{1'b0}};

`ifdef PIPE_STAGE_STATS_EN
  logic stallEn_s;
  logic bubbleEn_s;

  assign stallEn_s  = valid_o & ~ready_i;
  assign bubbleEn_s = ~valid_o & ~rst_i;

  pipe_sat_cnt u_stallCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (stallEn_s),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_cnt u_bubbleCnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (bubbleEn_s),
    .cnt_o (bubble_cnt_o)
  );
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register; successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque data payload plus a control-bit vector.
- Adds valid/ready handshaking with a 2-entry skid buffer for backpressure, plus synchronous flush.
- Control bits of a bubble read as zero, so a bubble never causes a write such as a RegWrite.

Parameters:
- DATA_W, 69, payload width in bits (MEM/WB: ReadData 32 + ALU data 32 + write address 5).
- CTRL_W, 2, control-bit width (MEM/WB: RegWrite, MemtoReg).

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush; discards all held and in-flight entries.
- valid_i  in  1  upstream entry valid.
- ready_o  out  1  stage can accept an entry this cycle.
- data_i  in  DATA_W  upstream payload.
- ctrl_i  in  CTRL_W  upstream control bits.
- valid_o  out  1  downstream entry valid.
- ready_i  in  1  downstream accepts this cycle.
- data_o  out  DATA_W  payload of the head entry.
- ctrl_o  out  CTRL_W  control bits of the head entry; zero when valid_o=0.

Behaviour:
- Storage: main register (head) and skid register, each holding data+ctrl.
- State is one of EMPTY, BUSY (main valid), FULL (main+skid valid).
- Transfers: in_xfer = valid_i & ready_o; out_xfer = valid_o & ready_i.
- Reset (rst_i high, asynchronous):
  - state=EMPTY; main and skid data/ctrl=0.
  - valid_o=0, data_o=0, ctrl_o=0, ready_o=0.
  - ready_o=1 from the first cycle after rst_i is released.
- Outputs:
  - ready_o = (state != FULL) & ~rst_i. It depends only on state, never on ready_i, so there is no combinational path from ready_i to ready_o.
  - valid_o = (state != EMPTY).
  - data_o = main data, registered. data_o holds its last value when EMPTY.
  - ctrl_o = main ctrl gated by valid_o.
- Latency: 1 cycle from in_xfer to valid_o. Throughput is 1 entry/cycle with ready_i held high.
- Transitions when flush_i=0:
  - EMPTY: valid_i -> main<=input, BUSY.
  - BUSY, valid_i & ready_i -> main<=input, stay BUSY.
  - BUSY, valid_i & ~ready_i -> skid<=input, FULL.
  - BUSY, ~valid_i & ready_i -> EMPTY.
  - BUSY, neither -> hold.
  - FULL: ready_i -> main<=skid, BUSY. ~ready_i -> hold. valid_i is ignored because ready_o=0.
- Ordering is strictly FIFO; no entry is ever duplicated or dropped without a flush.
- Flush (flush_i=1) has highest priority:
  - Next state is EMPTY.
  - Any same-cycle in_xfer is discarded.
  - Any same-cycle out_xfer still counts as consumed downstream.
  - ctrl of both registers is cleared to 0; data is retained.
  - ready_o stays per the current state during the flush cycle.
- Payload stability: while valid_o=1 and ready_i=0, data_o and ctrl_o must not change.
- Reset mid-operation: all entries are lost immediately, with no partial output.

Optional Feature:
- Macro PIPE_STAGE_STATS_EN.
- Defined: adds two outputs.
  - stall_cnt_o (32): counts cycles with valid_o=1 & ready_i=0.
  - bubble_cnt_o (32): counts cycles with valid_o=0 & ~rst_i.
  - Both saturate at 32'hFFFF_FFFF, reset to 0 on rst_i, and are unaffected by flush_i.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package pipe_pkg holds:
  - the stage state enum (EMPTY/BUSY/FULL, 2 bits);
  - the MEM/WB width constants (WB_DATA_W=69, WB_CTRL_W=2);
  - the counter width constant STAT_W=32.
- One sub-module, pipe_sat_cnt: STAT_W saturating counter with enable and async active-high reset, instantiated twice under PIPE_STAGE_STATS_EN.

Test Plan:
- Reset and release, then hold valid_i=0 -> valid_o=0, ctrl_o=0, data_o=0; ready_o=0 during reset and 1 the cycle after release.
- Stream 0x01..0x08, valid_i=1, ready_i=1 -> data_o yields 0x01..0x08 on consecutive cycles, 1 cycle after input; ready_o stays 1.
- Backpressure: send 0xA, 0xB with ready_i=0 -> FULL, ready_o=0, data_o=0xA held. Raise ready_i -> 0xA then 0xB, nothing lost, ready_o returns 1.
- Flush in FULL with concurrent valid_i=1 (0xC) -> next cycle valid_o=0, ctrl_o=0; 0xC not delivered; the next input 0xD is delivered alone.
- Assert rst_i asynchronously mid-stream while BUSY with ctrl=2'b11 -> ctrl_o and valid_o drop to 0 before the next clock edge.
- With PIPE_STAGE_STATS_EN: hold ready_i=0 for 5 cycles with an entry held -> stall_cnt_o=5. Preload counter to 0xFFFF_FFFE, stall 3 cycles -> stall_cnt_o=0xFFFF_FFFF.
